// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter and sequencer in front of the single-ported data memory.
// Port 0 is the core load/store unit and port 1 is the debug/DMA requester.
// Only one transaction is in flight at a time. Port 0 has fixed priority, and
// a starvation counter forces port 1 through after STARVE_MAX contested
// port-0 grants.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pN_req_i          request; req/we/addr/wdata held stable until pN_gnt_o
//   pN_we_i           1 = write, 0 = read
//   pN_addr_i         request address (passed through unmodified)
//   pN_wdata_i        write data
//   pN_gnt_o          combinational grant, only asserted in IDLE
//   pN_rvalid_o       one-cycle read-data valid pulse
//   pN_rdata_o        read data, valid with pN_rvalid_o
//   mem_addr_o        dmem address
//   mem_wdata_o       dmem write data
//   mem_write_o       dmem write strobe
//   mem_read_o        dmem read strobe
//   mem_rdata_i       dmem read data, READ_LAT cycles after a sampled read
//   busy_o            high in every state except IDLE
module dmem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_i,
  input  logic          p0_we_i,
  input  logic [AW-1:0] p0_addr_i,
  input  logic [DW-1:0] p0_wdata_i,
  output logic          p0_gnt_o,
  output logic          p0_rvalid_o,
  output logic [DW-1:0] p0_rdata_o,
  input  logic          p1_req_i,
  input  logic          p1_we_i,
  input  logic [AW-1:0] p1_addr_i,
  input  logic [DW-1:0] p1_wdata_i,
  output logic          p1_gnt_o,
  output logic          p1_rvalid_o,
  output logic [DW-1:0] p1_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int WCW = $clog2(READ_LAT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WCW-1:0]   wait_cnt;
  logic [SCW-1:0]   starve_cnt;
  logic             owner;
  logic             starved;

  assign starved = (starve_cnt == SCW'(STARVE_MAX));
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants only exist in IDLE. In ISSUE the registered write strobe still
  // holds the latched we bit, so it selects between finishing a write and
  // waiting out the read latency.
  always_comb begin
    state_nxt = state;
    p0_gnt_o  = 1'b0;
    p1_gnt_o  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (p0_req_i && !(p1_req_i && starved)) begin
            p0_gnt_o = 1'b1;
          end else if (p1_req_i) begin
            p1_gnt_o = 1'b1;
          end
        end
        if (p0_gnt_o || p1_gnt_o) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = mem_write_o ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == WCW'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The memory strobes and the rvalid pulses default low on every edge, so
  // each one is high for exactly the single cycle it is loaded. mem_addr_o and
  // mem_wdata_o double as the latched request and hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
      p0_rdata_o  <= '0;
      p1_rdata_o  <= '0;
      owner       <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
    end else begin
      mem_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;

      if (!p1_req_i || p1_gnt_o) begin
        starve_cnt <= '0;
      end else if (p0_gnt_o && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (p0_gnt_o || p1_gnt_o) begin
            owner       <= p1_gnt_o;
            mem_addr_o  <= p1_gnt_o ? p1_addr_i  : p0_addr_i;
            mem_wdata_o <= p1_gnt_o ? p1_wdata_i : p0_wdata_i;
            mem_write_o <= p1_gnt_o ? p1_we_i    : p0_we_i;
            mem_read_o  <= p1_gnt_o ? !p1_we_i   : !p0_we_i;
          end
        end
        ISSUE: begin
          wait_cnt <= WCW'(READ_LAT);
        end
        WAIT: begin
          if (wait_cnt == WCW'(1)) begin
            if (owner) begin
              p1_rdata_o  <= mem_rdata_i;
              p1_rvalid_o <= 1'b1;
            end else begin
              p0_rdata_o  <= mem_rdata_i;
              p0_rvalid_o <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A READ_LAT=1 instance is exercised by
// a vector table, directed corner-case sequences and random traffic, all
// checked every cycle against a transaction-level reference model. A second
// READ_LAT=2 instance checks the longer read latency.
module tb_dmem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int SMAX = 4;
  localparam int RING = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read, busy;

  logic          l2_p0_req, l2_p0_gnt, l2_p0_rvalid;
  logic [AW-1:0] l2_p0_addr;
  logic [DW-1:0] l2_p0_rdata;
  logic          l2_p1_gnt, l2_p1_rvalid;
  logic [DW-1:0] l2_p1_rdata;
  logic [AW-1:0] l2_mem_addr;
  logic [DW-1:0] l2_mem_wdata, l2_mem_rdata;
  logic          l2_mem_write, l2_mem_read, l2_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_read_o(mem_read), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(2), .STARVE_MAX(SMAX)) dut_l2 (
    .clk(clk), .rst(rst),
    .p0_req_i(l2_p0_req), .p0_we_i(1'b0), .p0_addr_i(l2_p0_addr), .p0_wdata_i(16'h0000),
    .p0_gnt_o(l2_p0_gnt), .p0_rvalid_o(l2_p0_rvalid), .p0_rdata_o(l2_p0_rdata),
    .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(16'h0000), .p1_wdata_i(16'h0000),
    .p1_gnt_o(l2_p1_gnt), .p1_rvalid_o(l2_p1_rvalid), .p1_rdata_o(l2_p1_rdata),
    .mem_addr_o(l2_mem_addr), .mem_wdata_o(l2_mem_wdata), .mem_write_o(l2_mem_write),
    .mem_read_o(l2_mem_read), .mem_rdata_i(l2_mem_rdata), .busy_o(l2_busy)
  );

  // dmem stand-in: read data is only valid in the exact cycle READ_LAT after
  // the sampled strobe; any other cycle shows a junk pattern.
  bit   [DW-1:0] dmem [0:65535];
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    rd_valid_q <= mem_read;
    rd_data_q  <= dmem[mem_addr];
  end
  assign mem_rdata = rd_valid_q ? rd_data_q : 16'h5A5A;

  logic [1:0] l2_rv_q;
  always @(posedge clk) l2_rv_q <= {l2_rv_q[0], l2_mem_read};
  assign l2_mem_rdata = l2_rv_q[1] ? 16'h0000 : 16'h5A5A;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: transaction timeline. A grant in cycle c puts the strobe
  // in c+1; a write frees the port at c+2, a read pulses rvalid at c+2+LAT
  // and frees it at c+3+LAT. Expected per-cycle events live in a ring.
  bit            sb_en = 1'b0;
  bit   [DW-1:0] ref_mem [0:65535];
  int            free_at = 0;
  int            starve  = 0;
  bit            exp_wr [RING], exp_rd [RING], exp_rv0 [RING], exp_rv1 [RING];
  logic [AW-1:0] exp_addr [RING];
  logic [DW-1:0] exp_wdata [RING], exp_rdata [RING];

  task automatic clearSlot(input int k);
    exp_wr[k] = 0; exp_rd[k] = 0; exp_rv0[k] = 0; exp_rv1[k] = 0;
  endtask

  task automatic modelStep();
    int s, t;
    bit idle, g0, g1, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    s    = cyc % RING;
    idle = (cyc >= free_at);
    g0   = 0;
    g1   = 0;
    if (!rst && idle) begin
      if (p0_req && !(p1_req && starve == SMAX)) g0 = 1;
      else if (p1_req) g1 = 1;
    end
    checkOutput("p0_gnt", p0_gnt, g0);
    checkOutput("p1_gnt", p1_gnt, g1);
    checkOutput("busy", busy, !idle);
    checkOutput("mem_write", mem_write, exp_wr[s]);
    checkOutput("mem_read", mem_read, exp_rd[s]);
    checkOutput("p0_rvalid", p0_rvalid, exp_rv0[s]);
    checkOutput("p1_rvalid", p1_rvalid, exp_rv1[s]);
    if (exp_wr[s] || exp_rd[s]) checkOutput("mem_addr", mem_addr, exp_addr[s]);
    if (exp_wr[s]) checkOutput("mem_wdata", mem_wdata, exp_wdata[s]);
    if (exp_rv0[s]) checkOutput("p0_rdata", p0_rdata, exp_rdata[s]);
    if (exp_rv1[s]) checkOutput("p1_rdata", p1_rdata, exp_rdata[s]);
    clearSlot(s);
    if (rst) begin
      free_at = cyc + 1;
      starve  = 0;
      for (int k = 0; k < RING; k++) clearSlot(k);
    end else begin
      if (!p1_req || g1) starve = 0;
      else if (g0 && starve < SMAX) starve++;
      if (g0 || g1) begin
        we = g1 ? p1_we : p0_we;
        a  = g1 ? p1_addr : p0_addr;
        d  = g1 ? p1_wdata : p0_wdata;
        t  = (cyc + 1) % RING;
        exp_wr[t] = we; exp_rd[t] = !we; exp_addr[t] = a; exp_wdata[t] = d;
        if (we) begin
          ref_mem[a] = d;
          free_at = cyc + 2;
        end else begin
          t = (cyc + 2 + LAT) % RING;
          if (g1) exp_rv1[t] = 1; else exp_rv0[t] = 1;
          exp_rdata[t] = ref_mem[a];
          free_at = cyc + 3 + LAT;
        end
      end
    end
  endtask

  always @(negedge clk) if (sb_en) modelStep();

  task automatic setPort(input bit port, input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end
  endtask

  // Raise one request, hold it until granted, then drop it after the edge.
  task automatic applyStimulus(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int gc);
    bit got = 0;
    gc = -1;
    @(posedge clk); #1;
    setPort(port, 1'b1, we, a, d);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_gnt : p0_gnt) begin
        got = 1;
        gc  = cyc;
      end
    end
    checkOutput("gnt_seen", got, 1);
    @(posedge clk); #1;
    setPort(port, 1'b0, we, a, d);
  endtask

  task automatic waitRead(input bit port, output logic [DW-1:0] data, output int rc);
    bit seen = 0;
    rc   = -1;
    data = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (port ? p1_rvalid : p0_rvalid) begin
        seen = 1;
        rc   = cyc;
        data = port ? p1_rdata : p0_rdata;
      end
    end
    checkOutput("rvalid_seen", seen, 1);
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
  } vec_t;

  vec_t vt [8];

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int g, rc, n0, p1c, g0c, g1c;
    bit p0_hit, p1_hit, pend0, pend1, gl0, gl1, any;
    logic [DW-1:0] rd;

    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    l2_p0_req = 0; l2_p0_addr = '0;

    vt[0] = '{1'b0, 1'b1, 16'h0000, 16'hABCD, 16'h0000, 0};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 3};
    vt[2] = '{1'b1, 1'b1, 16'h0004, 16'h1234, 16'h0000, 0};
    vt[3] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234, 3};
    vt[4] = '{1'b0, 1'b1, 16'hFFFC, 16'h0F0F, 16'h0000, 0};
    vt[5] = '{1'b1, 1'b0, 16'hFFFC, 16'h0000, 16'h0F0F, 3};
    vt[6] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, 3};
    vt[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 3};

    @(posedge clk); #1;
    sb_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_p0_rdata", p0_rdata, 16'h0000);
    checkOutput("rst_p1_rdata", p1_rdata, 16'h0000);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
    checkOutput("rst_l2_busy", l2_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table: single transactions with known read-back data.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, g);
      if (!vt[i].we) begin
        waitRead(vt[i].port, rd, rc);
        checkOutput($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
        checkOutput($sformatf("vec%0d_latency", i), rc - g, vt[i].lat);
      end
    end

    // Both ports request together: p0 read wins, p1 write follows at next IDLE.
    @(posedge clk); #1;
    setPort(0, 1, 0, 16'h0000, 16'h0000);
    setPort(1, 1, 1, 16'h0008, 16'h9ABC);
    g0c = -1; g1c = -1;
    for (int i = 0; i < 40 && (g0c < 0 || g1c < 0); i++) begin
      @(negedge clk);
      if (p0_gnt) g0c = cyc;
      if (p1_gnt) g1c = cyc;
      @(posedge clk); #1;
      if (g0c >= 0) p0_req = 0;
      if (g1c >= 0) p1_req = 0;
    end
    checkOutput("both_p0_first", (g0c >= 0 && g1c > g0c), 1);
    checkOutput("both_p1_delay", g1c - g0c, 3 + LAT);
    applyStimulus(0, 0, 16'h0008, 16'h0000, g);
    waitRead(0, rd, rc);
    checkOutput("both_readback", rd, 16'h9ABC);

    // Starvation: p1 held while p0 keeps writing; p1 gets the 5th contested grant.
    @(posedge clk); #1;
    setPort(0, 1, 1, 16'h0030, 16'h1111);
    setPort(1, 1, 1, 16'h0040, 16'h5555);
    n0 = 0; p1c = -1;
    for (int i = 0; i < 60 && p1c < 0; i++) begin
      @(negedge clk);
      p0_hit = p0_gnt;
      if (p0_gnt) n0++;
      if (p1_gnt) p1c = cyc;
      @(posedge clk); #1;
      if (p0_hit) begin
        p0_addr  = p0_addr + 16'd2;
        p0_wdata = p0_wdata + 16'd1;
      end
      if (p1c >= 0) setPort(1, 1, 1, 16'h0042, 16'h6666);
    end
    checkOutput("starve_p1_granted", p1c >= 0, 1);
    checkOutput("starve_p0_grants", n0, SMAX);
    any = 0;
    for (int i = 0; i < 20 && !any; i++) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) begin
        any = 1;
        checkOutput("starve_cleared_p0_wins", p0_gnt, 1);
      end
    end
    checkOutput("starve_next_grant_seen", any, 1);
    @(posedge clk); #1;
    p0_req = 0;
    any = 0;
    for (int i = 0; i < 20 && !any; i++) begin
      @(negedge clk);
      any = p1_gnt;
    end
    checkOutput("starve_p1_final_gnt", any, 1);
    @(posedge clk); #1;
    p1_req = 0;

    // Reset during the WAIT cycle of a p0 read of 0xFFFC.
    applyStimulus(0, 0, 16'hFFFC, 16'h0000, g);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mem_read", mem_read, 0);
    checkOutput("abort_mem_write", mem_write, 0);
    checkOutput("abort_p0_rvalid", p0_rvalid, 0);
    checkOutput("abort_p0_rdata", p0_rdata, 16'h0000);
    applyStimulus(0, 1, 16'hFFFC, 16'hDEAD, g);
    applyStimulus(0, 0, 16'hFFFC, 16'h0000, g);
    waitRead(0, rd, rc);
    checkOutput("abort_readback", rd, 16'hDEAD);

    // READ_LAT=2 instance: uninitialised read returns zero one cycle later.
    @(posedge clk); #1;
    l2_p0_req = 1; l2_p0_addr = 16'h0010;
    g = -1;
    for (int i = 0; i < 10 && g < 0; i++) begin
      @(negedge clk);
      if (l2_p0_gnt) g = cyc;
    end
    @(posedge clk); #1;
    l2_p0_req = 0;
    rc = -1;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      @(negedge clk);
      if (l2_p0_rvalid) begin
        rc = cyc;
        rd = l2_p0_rdata;
      end
    end
    checkOutput("l2_gnt_seen", g >= 0, 1);
    checkOutput("l2_latency", rc - g, 4);
    checkOutput("l2_rdata", rd, 16'h0000);

    // Random traffic on both ports, judged cycle by cycle by the model.
    pend0 = 0; pend1 = 0; gl0 = 0; gl1 = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (gl0) begin p0_req = 0; pend0 = 0; end
      if (gl1) begin p1_req = 0; pend1 = 0; end
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1;
        setPort(0, 1, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 3) * 2), 16'($urandom));
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1;
        setPort(1, 1, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 3) * 2), 16'($urandom));
      end
      @(negedge clk);
      gl0 = p0_gnt;
      gl1 = p1_gnt;
    end
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported data memory (dmem).
- Port 0 is the core load/store unit; port 1 is the debug/DMA requester.
- Exactly one transaction is in flight at a time.
- The block drives dmem's address, write data, write strobe and read strobe, and returns read data to the granted requester with a valid pulse.
- Fixed priority goes to port 0, with a starvation guard for port 1.

Parameters:
AW, 16, address width
DW, 16, data width
READ_LAT, 1, cycles from the edge that samples mem_read_o high until mem_rdata_i is valid (minimum 1)
STARVE_MAX, 4, consecutive port-0 grants while port 1 is waiting before port 1 is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
p0_req_i  in  1  port-0 request; req/we/addr/wdata held stable until p0_gnt_o
p0_we_i  in  1  1 = write, 0 = read
p0_addr_i  in  AW  port-0 address
p0_wdata_i  in  DW  port-0 write data
p0_gnt_o  out  1  grant; combinational, IDLE state only
p0_rvalid_o  out  1  one-cycle read-data valid pulse
p0_rdata_o  out  DW  read data, valid when p0_rvalid_o is high
p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o  same as port 0, for port 1
mem_addr_o  out  AW  to dmem address
mem_wdata_o  out  DW  to dmem mem_data
mem_write_o  out  1  to dmem mem_write_i
mem_read_o  out  1  to dmem mem_read_i
mem_rdata_i  in  DW  from dmem read_data_o
busy_o  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except gnt.
- Reset: state=IDLE; all mem_*, rvalid, rdata, starve counter and owner = 0.
  - Reset asserted mid-transaction abandons it: no rvalid, mem strobes low the next cycle.
  - gnt_o is forced 0 while rst is high.
- IDLE: if any request is present, assert exactly one gnt.
  - On that edge, latch addr, wdata, we and owner, then go to ISSUE.
- Arbitration:
  - Port 0 wins, unless both request and starve_cnt == STARVE_MAX; then port 1 wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each port-0 grant while p1_req_i is high.
  - starve_cnt clears on a port-1 grant or whenever p1_req_i is low.
- ISSUE (1 cycle): mem_addr_o/mem_wdata_o = latched values; mem_write_o = we; mem_read_o = !we.
  - Write goes to IDLE; no response is produced.
  - Read goes to WAIT with wait_cnt = READ_LAT.
- WAIT: mem strobes are 0; mem_addr_o holds its value.
  - Decrement wait_cnt each cycle.
  - When wait_cnt == 1, capture mem_rdata_i and go to RESP.
- RESP (1 cycle): owner's rvalid_o = 1 with rdata_o = captured data; the other port's rvalid stays 0. Then go to IDLE.
  - rdata_o holds its value until the next capture.
- Latency with READ_LAT=1:
  - Read: gnt at cycle N, mem_read_o at N+1, capture at N+2, rvalid at N+3; next grant possible at N+4.
  - Write: gnt at N, mem_write_o at N+1; next grant at N+2.
- mem_write_o and mem_read_o are never high together.
- Requests that arrive while busy are not granted; the requester holds.
- Address is passed through unmodified, with no alignment check; 0xFFFC is legal.

Test Plan:
- Reset, then p0 write 0x0000 <- 0xABCD, then p0 read 0x0000 -> gnt at N, mem_write_o at N+1; read rvalid at N'+3 with p0_rdata_o = 0xABCD.
- p1 write 0x0004 <- 0x1234, then p1 read 0x0004 -> p1_rvalid_o pulses with 0x1234; p0_rvalid_o stays 0 throughout.
- Both requesting in the same cycle (p0 read 0x0000, p1 write 0x0008 <- 0x9ABC) -> p0 granted first, p1 granted at the first IDLE after; a later read of 0x0008 returns 0x9ABC.
- p1_req_i held high while p0 issues back-to-back writes -> 5th contested grant goes to p1 (STARVE_MAX=4); starve_cnt then clears.
- rst asserted in the WAIT cycle of a p0 read of 0xFFFC -> no rvalid, busy_o=0 and all mem strobes 0 the next cycle; a subsequent write of 0xFFFC <- 0xDEAD then read returns 0xDEAD.
- READ_LAT=2 build: read of 0x0010 (uninitialised) -> rvalid at N+4 with rdata 0x0000.
